// File: rtl/ysyx_25040111_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_wb_sched_pkg
// Brief    : Shared constants for the write-back scheduler slice
//            (register-index width, default data width, source encoding).
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25040111_wb_sched_pkg;

  // Width of an architectural register index (x0..x31)
  localparam int REG_W = 5;

  // Default result / register-file data width
  localparam int XLEN_DEF = 32;

  // Write-back source encoding, also used as the round-robin history value
  localparam logic WB_SRC_EXU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ysyx_25040111_wb_buf.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_wb_buf
// Brief    : One-entry holding register (valid/rd/data) for a single
//            write-back source. Accepts a new result whenever empty or when
//            the held entry is being written this cycle, unless blocked.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_wb_buf
  import ysyx_25040111_wb_sched_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [REG_W-1:0] in_rd_i,
  input  logic [XLEN-1:0]  in_data_i,
  input  logic             block_i,
  input  logic             grant_i,
  output logic             valid_o,
  output logic [REG_W-1:0] rd_o,
  output logic [XLEN-1:0]  data_o
);

  logic             valid_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0]  data_q;
  logic             w_accept;

  // A granted entry leaves this cycle, so its slot can be refilled at once.
  assign in_ready_o = (!valid_q || grant_i) && !block_i;
  assign w_accept   = in_valid_i && in_ready_o;

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

  // Load on handshake (overwriting a granted entry), otherwise drain on grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else if (w_accept) begin
      valid_q <= 1'b1;
      rd_q    <= in_rd_i;
      data_q  <= in_data_i;
    end else if (grant_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_25040111_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_wb_sched
// Brief    : Write-back scheduler. Buffers one EXU and one LSU result,
//            grants the single register-file write port round-robin, tracks
//            outstanding loads in a scoreboard for decode hazards, and
//            counts retired write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_wb_sched
  import ysyx_25040111_wb_sched_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [REG_W-1:0] exu_rd,
  input  logic [XLEN-1:0]  exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [REG_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_rd,
  input  logic [REG_W-1:0] chk_rs1,
  input  logic [REG_W-1:0] chk_rs2,
  input  logic [REG_W-1:0] chk_rd,
  output logic             hz_stall,
  output logic             rf_wen,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic             last_grant_q;
  logic [CNT_W-1:0] retire_cnt_q;

  logic             w_exu_waw;
  logic             w_ebuf_valid, w_lbuf_valid;
  logic [REG_W-1:0] w_ebuf_rd, w_lbuf_rd;
  logic [XLEN-1:0]  w_ebuf_data, w_lbuf_data;
  logic             w_grant_exu, w_grant_lsu, w_grant_any;

  // EXU may not overwrite a register whose load result is still outstanding.
  assign w_exu_waw = busy_q[exu_rd] && (exu_rd != '0);

  ysyx_25040111_wb_buf #(.XLEN(XLEN)) u_exu_buf (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (exu_valid),
    .in_ready_o (exu_ready),
    .in_rd_i    (exu_rd),
    .in_data_i  (exu_data),
    .block_i    (w_exu_waw),
    .grant_i    (w_grant_exu),
    .valid_o    (w_ebuf_valid),
    .rd_o       (w_ebuf_rd),
    .data_o     (w_ebuf_data)
  );

  ysyx_25040111_wb_buf #(.XLEN(XLEN)) u_lsu_buf (
    .clock      (clock),
    .reset      (reset),
    .in_valid_i (lsu_valid),
    .in_ready_o (lsu_ready),
    .in_rd_i    (lsu_rd),
    .in_data_i  (lsu_data),
    .block_i    (1'b0),
    .grant_i    (w_grant_lsu),
    .valid_o    (w_lbuf_valid),
    .rd_o       (w_lbuf_rd),
    .data_o     (w_lbuf_data)
  );

  // Round-robin: a lone valid buffer wins; on a tie the source not served last wins.
  always_comb begin
    w_grant_exu = w_ebuf_valid && (!w_lbuf_valid || (last_grant_q == WB_SRC_LSU));
    w_grant_lsu = w_lbuf_valid && !w_grant_exu;
    w_grant_any = w_grant_exu || w_grant_lsu;
  end

  // Register-file write port driven straight from the granted buffer.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_grant_exu) begin
      rf_wen   = (w_ebuf_rd != '0);
      rf_waddr = w_ebuf_rd;
      rf_wdata = w_ebuf_data;
    end else if (w_grant_lsu) begin
      rf_wen   = (w_lbuf_rd != '0);
      rf_waddr = w_lbuf_rd;
      rf_wdata = w_lbuf_data;
    end
  end

  assign retire     = w_grant_any;
  assign retire_cnt = retire_cnt_q;

  // Decode stalls on any operand whose load is outstanding; no same-cycle bypass.
  assign hz_stall = (busy_q[chk_rs1] && (chk_rs1 != '0)) ||
                    (busy_q[chk_rs2] && (chk_rs2 != '0)) ||
                    (busy_q[chk_rd]  && (chk_rd  != '0));

  // Scoreboard next state: clear on LSU write, then a new load to the same reg re-sets it.
  always_comb begin
    busy_d = busy_q;
    if (w_grant_lsu) begin
      busy_d[w_lbuf_rd] = 1'b0;
    end
    if (ld_issue && (ld_rd != '0)) begin
      busy_d[ld_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard, round-robin history and retire counter state.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q       <= '0;
      last_grant_q <= WB_SRC_LSU;
      retire_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (w_grant_any) begin
        last_grant_q <= w_grant_lsu ? WB_SRC_LSU : WB_SRC_EXU;
        retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_wb_sched
// Brief    : Self-checking bench for the write-back scheduler: directed
//            scenarios followed by random traffic, all compared against a
//            behavioural model of pending results and outstanding loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_wb_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd, chk_rs1, chk_rs2, chk_rd;
  logic        hz_stall, rf_wen, retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_25040111_wb_sched #(.XLEN(32), .NREG(32), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hz_stall(hz_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .retire_cnt(retire_cnt)
  );

  // Behavioural model: one pending result per source, set of registers with
  // loads outstanding, who was served last, and how many results retired.
  bit          m_ev, m_lv;
  logic [4:0]  m_erd, m_lrd;
  logic [31:0] m_edata, m_ldata;
  bit [31:0]   m_busy;
  bit          m_last_lsu;
  logic [31:0] m_cnt;

  // Predictions for the current cycle
  bit          p_ge, p_gl, p_eready, p_lready, p_hz, p_wen;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;

  function automatic bit pending(input bit [31:0] b, input logic [4:0] r);
    return (r != 5'd0) && b[r];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ev = 0; m_lv = 0; m_erd = '0; m_lrd = '0; m_edata = '0; m_ldata = '0;
    m_busy = '0; m_last_lsu = 1; m_cnt = '0;
  endtask

  task automatic predict();
    if (m_ev && m_lv) begin
      p_ge = m_last_lsu;          // serve whoever was not served last
      p_gl = !m_last_lsu;
    end else begin
      p_ge = m_ev;
      p_gl = m_lv;
    end
    p_eready = (!m_ev || p_ge) && !pending(m_busy, exu_rd);
    p_lready = !m_lv || p_gl;
    p_hz     = pending(m_busy, chk_rs1) || pending(m_busy, chk_rs2) || pending(m_busy, chk_rd);
    p_waddr  = p_ge ? m_erd   : (p_gl ? m_lrd   : 5'd0);
    p_wdata  = p_ge ? m_edata : (p_gl ? m_ldata : 32'd0);
    p_wen    = (p_ge || p_gl) && (p_waddr != 5'd0);
  endtask

  task automatic compare_all();
    predict();
    check("exu_ready",  32'(exu_ready),  32'(p_eready));
    check("lsu_ready",  32'(lsu_ready),  32'(p_lready));
    check("hz_stall",   32'(hz_stall),   32'(p_hz));
    check("rf_wen",     32'(rf_wen),     32'(p_wen));
    check("rf_waddr",   32'(rf_waddr),   32'(p_waddr));
    check("rf_wdata",   rf_wdata,        p_wdata);
    check("retire",     32'(retire),     32'(p_ge || p_gl));
    check("retire_cnt", retire_cnt,      m_cnt);
  endtask

  task automatic model_step();
    bit ea, la;
    predict();
    if (reset) begin
      model_reset();
    end else begin
      ea = exu_valid && p_eready;
      la = lsu_valid && p_lready;
      if (p_ge || p_gl) begin
        m_cnt      = m_cnt + 32'd1;
        m_last_lsu = p_gl;
      end
      if (p_gl && m_lrd != 5'd0) m_busy[m_lrd] = 1'b0;
      if (ld_issue && ld_rd != 5'd0) m_busy[ld_rd] = 1'b1;
      if (ea) begin m_ev = 1; m_erd = exu_rd; m_edata = exu_data; end
      else if (p_ge) m_ev = 0;
      if (la) begin m_lv = 1; m_lrd = lsu_rd; m_ldata = lsu_data; end
      else if (p_gl) m_lv = 0;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic idle();
    exu_valid = 0; exu_rd = '0; exu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    ld_issue = 0; ld_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  initial begin
    logic [4:0] exp_addr [4];
    logic       exp_erdy [4];
    int ei, li;
    bit ea, la;

    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_erdy = '{1'b1, 1'b0, 1'b1, 1'b0};

    idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;

    // Reset state
    sample();
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_hz", 32'(hz_stall), 32'd0);
    check("rst_exu_ready", 32'(exu_ready), 32'd1);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    advance();

    // Single EXU result: written the cycle after acceptance
    exu_valid = 1; exu_rd = 5'd5; exu_data = 32'h1234;
    sample();
    advance();
    idle();
    sample();
    check("a_wen", 32'(rf_wen), 32'd1);
    check("a_waddr", 32'(rf_waddr), 32'd5);
    check("a_wdata", rf_wdata, 32'h1234);
    check("a_retire", 32'(retire), 32'd1);
    advance();
    sample();
    check("a_cnt", retire_cnt, 32'd1);
    advance();

    // Load hazard on x7 holds through the write cycle, drops afterwards
    ld_issue = 1; ld_rd = 5'd7;
    cyc();
    idle();
    chk_rs1 = 5'd7;
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'hdeadbeef;
    sample();
    check("b_hz_pend", 32'(hz_stall), 32'd1);
    advance();
    lsu_valid = 0;
    sample();
    check("b_waddr", 32'(rf_waddr), 32'd7);
    check("b_wdata", rf_wdata, 32'hdeadbeef);
    check("b_hz_write", 32'(hz_stall), 32'd1);
    advance();
    sample();
    check("b_hz_after", 32'(hz_stall), 32'd0);
    advance();
    idle();

    // Both sources streaming: grants alternate starting with EXU
    ei = 0; li = 0;
    for (int c = 0; c < 5; c++) begin
      exu_valid = 1; exu_rd = 5'(1 + 2 * ei); exu_data = 32'h100 + 32'(ei);
      lsu_valid = 1; lsu_rd = 5'(2 + 2 * li); lsu_data = 32'h200 + 32'(li);
      sample();
      if (c >= 1) begin
        check("c_retire", 32'(retire), 32'd1);
        check("c_waddr", 32'(rf_waddr), 32'(exp_addr[c-1]));
        check("c_exu_ready", 32'(exu_ready), 32'(exp_erdy[c-1]));
      end
      ea = exu_valid && exu_ready;
      la = lsu_valid && lsu_ready;
      advance();
      if (ea) ei++;
      if (la) li++;
    end
    idle();
    repeat (4) cyc();

    // WAW guard on x9, then an EXU write to x0
    ld_issue = 1; ld_rd = 5'd9;
    cyc();
    idle();
    exu_valid = 1; exu_rd = 5'd9; exu_data = 32'h99;
    sample();
    check("d_blocked", 32'(exu_ready), 32'd0);
    advance();
    cyc();
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h900;
    cyc();
    lsu_valid = 0;
    sample();
    check("d_lsu_write", 32'(rf_waddr), 32'd9);
    check("d_still_blocked", 32'(exu_ready), 32'd0);
    advance();
    sample();
    check("d_unblocked", 32'(exu_ready), 32'd1);
    advance();
    idle();
    cyc();
    exu_valid = 1; exu_rd = 5'd0; exu_data = 32'h5;
    cyc();
    idle();
    sample();
    check("d_x0_retire", 32'(retire), 32'd1);
    check("d_x0_wen", 32'(rf_wen), 32'd0);
    advance();

    // New load to x3 issued while the previous x3 load writes: set wins
    ld_issue = 1; ld_rd = 5'd3;
    cyc();
    idle();
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 32'h33;
    cyc();
    lsu_valid = 0;
    ld_issue = 1; ld_rd = 5'd3;
    sample();
    check("e_lsu_write", 32'(rf_waddr), 32'd3);
    advance();
    idle();
    chk_rs2 = 5'd3;
    sample();
    check("e_hz", 32'(hz_stall), 32'd1);
    advance();
    idle();

    // Random traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      reset     = (i == 200);
      exu_valid = 1'($urandom_range(0, 1));
      exu_rd    = 5'($urandom_range(0, 7));
      exu_data  = $urandom;
      lsu_valid = 1'($urandom_range(0, 1));
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_data  = $urandom;
      ld_issue  = ($urandom_range(0, 3) == 0);
      ld_rd     = 5'($urandom_range(0, 7));
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      chk_rd    = 5'($urandom_range(0, 7));
      cyc();
    end
    reset = 0;
    idle();
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
